// File: rtl/if_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_unit_pkg
//  Description : Shared fetch-pipeline definitions: FSM state encoding,
//                instruction width, NOP word and an address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package if_prefetch_unit_pkg;

    localparam int INST_WIDTH  = 32;
    localparam int ENTRY_WIDTH = 2 * INST_WIDTH;   // {pc, instruction}

    localparam logic [INST_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

    // IDLE: nothing outstanding, WAIT: request outstanding,
    // DISCARD: request outstanding but its response must be dropped.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // Fetch addresses are always word aligned.
    function automatic logic [INST_WIDTH-1:0] word_align(input logic [INST_WIDTH-1:0] addr);
        return {addr[INST_WIDTH-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_unit_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : prefetch_fifo
//  Description : DEPTH-entry synchronous FIFO of {pc, instruction} pairs with
//                clear, occupancy count and a combinational head word.
//  Revision    : 1.0  initial release
// ============================================================================
module prefetch_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [ENTRY_WIDTH-1:0]     wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ENTRY_WIDTH-1:0]     head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    // Pointer and occupancy bookkeeping; clear overrides push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because reads are gated by count.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    // An empty FIFO presents all zeros so the consumer sees PC 0 / NOP.
    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_unit
//  Description : Instruction prefetcher. Issues one word request at a time to
//                instruction memory, buffers responses with their PCs and
//                presents the head entry downstream. Handles stall, flush and
//                redirect, dropping responses of abandoned requests.
//  Revision    : 1.0  initial release
// ============================================================================
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        inst_valid
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    fetch_state_t           state;
    fetch_state_t           state_next;
    logic                   issue;
    logic [31:0]            fetch_pc;
    logic [31:0]            req_addr;
    logic [CW-1:0]          count;
    logic [ENTRY_WIDTH-1:0] head;
    logic                   kill;
    logic                   buf_valid;
    logic                   do_pop;
    logic                   do_push;
    logic                   room;

    assign kill      = flush | redirect_valid;
    assign buf_valid = (count != '0);
    assign do_pop    = buf_valid & ~stall & ~kill;
    assign do_push   = (state == ST_WAIT) & imem_ack & ~kill;
    // A slot freed by this cycle's pop counts as room for the next request.
    assign room      = (count != FULL_COUNT) | do_pop;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .clear (kill),
        .wdata ({req_addr, imem_rdata}),
        .count (count),
        .head  (head)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM next-state and request-issue decision.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!kill && room) begin
                    state_next = ST_WAIT;
                    issue      = 1'b1;
                end
            end
            ST_WAIT: begin
                // An ack coinciding with a kill still closes the transaction;
                // its data is simply not pushed.
                if (imem_ack)  state_next = ST_IDLE;
                else if (kill) state_next = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (imem_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Fetch PC and the held request address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= word_align(RESET_PC);
            req_addr <= '0;
        end else begin
            if (issue) req_addr <= fetch_pc;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
            end else if (flush) begin
                // Resume at the oldest instruction not yet consumed.
                if (buf_valid)               fetch_pc <= head[ENTRY_WIDTH-1:INST_WIDTH];
                else if (state == ST_WAIT)   fetch_pc <= req_addr;
            end else if (do_push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    assign imem_req        = (state != ST_IDLE);
    assign imem_addr       = req_addr;
    assign inst_valid      = buf_valid;
    assign pc_out          = head[ENTRY_WIDTH-1:INST_WIDTH];
    assign instruction_out = buf_valid ? head[INST_WIDTH-1:0] : NOP_WORD;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_prefetch_unit
//  Description : Self-checking bench for if_prefetch_unit: directed scenarios
//                plus a randomized run against a program-order fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        inst_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    if_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .inst_valid      (inst_valid)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Apply one cycle of inputs (ack only answers a live request), then
    // advance to 1 time unit after the next rising edge.
    task automatic drive(input logic s, input logic f, input logic rv,
                         input logic [31:0] rpc, input logic a);
        stall          = s;
        flush          = f;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = a & imem_req;
        imem_rdata     = imem_ack ? mem_word(imem_addr) : 32'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags: req/valid=%b expected 00", {imem_req, inst_valid});
        end
        tests_run++;
        if (imem_addr !== 32'h0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_values: addr=%h pc=%h instr=%h expected all 0",
                     imem_addr, pc_out, instruction_out);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_req: got %b expected 0", imem_req);
        end
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL first_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream;
        logic [31:0] pcs [4];
        logic [31:0] words [4];
        int          cyc [4];
        int          found = 0;
        int          c = 0;
        do_reset();
        while (found < 4 && c < 40) begin
            if (inst_valid) begin
                pcs[found]   = pc_out;
                words[found] = instruction_out;
                cyc[found]   = c;
                found++;
            end
            drive(0, 0, 0, 32'h0, 1);
            c++;
        end
        tests_run++;
        if (found != 4) begin
            tests_failed++;
            $display("FAIL stream_timeout: got %0d instructions expected 4", found);
        end
        for (int i = 0; i < found; i++) begin
            tests_run++;
            if (pcs[i] !== 32'(4 * i) || words[i] !== mem_word(32'(4 * i))) begin
                tests_failed++;
                $display("FAIL stream_pc%0d: pc=%h instr=%h expected %h %h",
                         i, pcs[i], words[i], 32'(4 * i), mem_word(32'(4 * i)));
            end
            if (i > 0) begin
                tests_run++;
                if (cyc[i] - cyc[i-1] != 2) begin
                    tests_failed++;
                    $display("FAIL stream_spacing%0d: gap=%0d expected 2", i, cyc[i] - cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall_fill;
        int acks = 0;
        do_reset();
        repeat (12) begin
            if (imem_req) acks++;
            drive(1, 0, 0, 32'h0, 1);
        end
        tests_run++;
        if (acks != 4) begin
            tests_failed++;
            $display("FAIL fill_count: got %0d buffered expected 4", acks);
        end
        tests_run++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1 || pc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL fill_hold: req=%b valid=%b pc=%h expected 0 1 00000000",
                     imem_req, inst_valid, pc_out);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (inst_valid !== 1'b1 || pc_out !== 32'(4 * i) ||
                instruction_out !== mem_word(32'(4 * i))) begin
                tests_failed++;
                $display("FAIL drain%0d: valid=%b pc=%h instr=%h expected 1 %h %h",
                         i, inst_valid, pc_out, instruction_out, 32'(4 * i), mem_word(32'(4 * i)));
            end
            drive(0, 0, 0, 32'h0, 1);
        end
    endtask

    task automatic test_redirect_wait;
        logic seen_req = 1'b0;
        logic seen_val = 1'b0;
        int   c = 0;
        do_reset();
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL redir_wait_entry: req=%b addr=%h expected 1 0", imem_req, imem_addr);
        end
        drive(0, 0, 1, 32'h0000_0100, 0);
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redir_discard_hold: req=%b addr=%h valid=%b expected 1 0 0",
                     imem_req, imem_addr, inst_valid);
        end
        drive(0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 1);
        while ((!seen_req || !seen_val) && c < 20) begin
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                tests_run++;
                if (imem_addr !== 32'h0000_0100) begin
                    tests_failed++;
                    $display("FAIL redir_next_addr: got %h expected 00000100", imem_addr);
                end
            end
            if (inst_valid && !seen_val) begin
                seen_val = 1'b1;
                tests_run++;
                if (pc_out !== 32'h0000_0100 || instruction_out !== mem_word(32'h100)) begin
                    tests_failed++;
                    $display("FAIL redir_first_valid: pc=%h instr=%h expected 00000100 %h",
                             pc_out, instruction_out, mem_word(32'h100));
                end
            end
            drive(0, 0, 0, 32'h0, 1);
            c++;
        end
        tests_run++;
        if (!seen_req || !seen_val) begin
            tests_failed++;
            $display("FAIL redir_timeout: req_seen=%b valid_seen=%b expected 1 1", seen_req, seen_val);
        end
    endtask

    task automatic test_flush_buffer;
        int acks = 0;
        int c = 0;
        do_reset();
        drive(1, 0, 1, 32'h0000_0020, 0);
        while (acks < 2 && c < 20) begin
            if (imem_req) acks++;
            drive(1, 0, 0, 32'h0, 1);
            c++;
        end
        tests_run++;
        if (acks != 2 || inst_valid !== 1'b1 || pc_out !== 32'h20) begin
            tests_failed++;
            $display("FAIL flush_setup: acks=%0d valid=%b pc=%h expected 2 1 00000020",
                     acks, inst_valid, pc_out);
        end
        drive(1, 1, 0, 32'h0, 0);
        tests_run++;
        if (inst_valid !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_empty: valid=%b pc=%h instr=%h expected 0 0 0",
                     inst_valid, pc_out, instruction_out);
        end
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            tests_failed++;
            $display("FAIL flush_refetch: req=%b addr=%h expected 1 00000020", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midreq;
        do_reset();
        drive(0, 0, 1, 32'h0000_0080, 0);
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            tests_failed++;
            $display("FAIL midreq_setup: req=%b addr=%h expected 1 00000080", imem_req, imem_addr);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreq_async: req=%b addr=%h valid=%b expected 0 0 0",
                     imem_req, imem_addr, inst_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL midreq_restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] addrs [2];
        logic [31:0] pcs [2];
        int          nr = 0;
        int          nv = 0;
        int          c = 0;
        do_reset();
        drive(0, 0, 1, 32'hFFFF_FFFF, 0);
        while ((nr < 2 || nv < 2) && c < 30) begin
            if (imem_req && nr < 2) begin
                addrs[nr] = imem_addr;
                nr++;
            end
            if (inst_valid && nv < 2) begin
                pcs[nv] = pc_out;
                nv++;
            end
            drive(0, 0, 0, 32'h0, 1);
            c++;
        end
        tests_run++;
        if (nr != 2 || nv != 2) begin
            tests_failed++;
            $display("FAIL wrap_timeout: reqs=%0d valids=%0d expected 2 2", nr, nv);
        end else begin
            tests_run++;
            if (addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
                tests_failed++;
                $display("FAIL wrap_addr: got %h %h expected fffffffc 00000000", addrs[0], addrs[1]);
            end
            tests_run++;
            if (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
                tests_failed++;
                $display("FAIL wrap_pc: got %h %h expected fffffffc 00000000", pcs[0], pcs[1]);
            end
        end
    endtask

    // Random stall/ack/flush/redirect traffic. The model only knows program
    // order: instructions leave in ascending word order from the last redirect
    // target, each carrying the memory word of its PC; flush alone never
    // changes which instruction comes next.
    task automatic test_random;
        logic [31:0] exp_pc    = RESET_PC;
        logic        pending   = 1'b0;
        logic [31:0] held_addr = 32'h0;
        int          delivered = 0;
        logic        s, f, r, a;
        logic [31:0] rpc;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (pending) begin
                tests_run++;
                if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                    tests_failed++;
                    $display("FAIL rand_req_hold: req=%b addr=%h expected 1 %h",
                             imem_req, imem_addr, held_addr);
                end
            end
            if (!inst_valid) begin
                tests_run++;
                if (pc_out !== 32'h0 || instruction_out !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL rand_empty_nop: pc=%h instr=%h expected 0 0", pc_out, instruction_out);
                end
            end
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 40) == 0);
            f   = !r && ($urandom_range(0, 40) == 0);
            a   = ($urandom_range(0, 2) != 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            if (inst_valid && !s && !f && !r) begin
                tests_run++;
                if (pc_out !== exp_pc || instruction_out !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL rand_deliver: pc=%h instr=%h expected %h %h",
                             pc_out, instruction_out, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (r) exp_pc = rpc & 32'hFFFF_FFFC;
            pending   = imem_req && !a;
            held_addr = imem_addr;
            drive(s, f, r, rpc, a);
        end
        tests_run++;
        if (delivered < 200) begin
            tests_failed++;
            $display("FAIL rand_progress: delivered %0d expected at least 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_redirect_wait();
        test_flush_buffer();
        test_reset_midreq();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of prefetch buffer entries (power of two, minimum 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  downstream hold; head entry is not consumed while high.
REQ-006 flush  input  1  discard all buffered and in-flight instructions.
REQ-007 redirect_valid  input  1  branch/jump target is valid this cycle; implies flush.
REQ-008 redirect_pc  input  32  new fetch address, qualified by redirect_valid.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  word-aligned request address.
REQ-011 imem_ack  input  1  memory response valid; completes the outstanding request.
REQ-012 imem_rdata  input  32  instruction word, qualified by imem_ack.
REQ-013 pc_out  output  32  PC of the head instruction.
REQ-014 instruction_out  output  32  head instruction word.
REQ-015 inst_valid  output  1  head entry present.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (request outstanding, response to be dropped).
REQ-017 IDLE->WAIT when count+0 < DEPTH and no flush: assert imem_req with imem_addr=fetch_pc.
REQ-018 At most one outstanding request; imem_req and imem_addr are held stable until imem_ack.
REQ-019 imem_ack may arrive in the same cycle imem_req rises, or any later cycle.
REQ-020 WAIT with imem_ack: push {imem_addr, imem_rdata} into the buffer, fetch_pc += 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), then go to IDLE.
REQ-021 A new request is issued no earlier than the cycle after the ack; the sustained rate is one instruction per two cycles.
REQ-022 Head entry is consumed when inst_valid=1 and stall=0.
REQ-023 A push and a pop in the same cycle leave count unchanged.
REQ-024 A request is issued only if count < DEPTH, counting an entry popped that cycle; the buffer cannot overflow.
REQ-025 When the buffer is empty: inst_valid=0, instruction_out=32'h0 (NOP), pc_out=32'h0.
REQ-026 Latency: an ack in cycle N with an empty buffer gives inst_valid=1 with that word in cycle N+1.
REQ-027 Flush or redirect empties the buffer in the same cycle; pop and push in that cycle are suppressed.
REQ-028 Flush priority: redirect sets fetch_pc to redirect_pc. Flush alone sets fetch_pc to the head PC if the buffer is non-empty; otherwise fetch_pc keeps its value, and if a request is outstanding, fetch_pc is set to that request's address.
REQ-029 Flush/redirect in WAIT without imem_ack -> DISCARD. Flush/redirect in WAIT with imem_ack -> data dropped, go to IDLE.
REQ-030 DISCARD keeps imem_req high with the old address until imem_ack, drops the data, then goes to IDLE.
REQ-031 Flush/redirect during DISCARD updates fetch_pc only.
REQ-032 redirect_pc[1:0] is ignored; fetch addresses are always word-aligned.

Reset
REQ-033 Reset forces state=IDLE, count=0, and fetch_pc=RESET_PC.
REQ-034 Reset forces imem_req=0, imem_addr=0, inst_valid=0, instruction_out=0, and pc_out=0, asynchronously.
REQ-035 Reset mid-request abandons the transaction; the memory side tolerates a deasserted req.
REQ-036 The first imem_req rises in the first clock edge after reset deasserts, with address RESET_PC.

Structure
REQ-037 The shared pipeline package holds the FSM state encoding, the NOP word (32'h0), and the instruction width constant 32.
REQ-038 One sub-module, prefetch_fifo: a DEPTH-entry 64-bit synchronous FIFO with push, pop, clear, count, and the head word; the FSM and PC logic stay in the top.

Verification
REQ-039 Reset release, ack one cycle after every req, stall=0 -> pc_out sequence 0,4,8,12 with inst_valid pulsing every second cycle.
REQ-040 stall=1 held for 12 cycles with instant acks -> exactly 4 entries buffered, imem_req stays low, head pc_out=0 held; release stall -> 0,4,8,12 delivered back-to-back.
REQ-041 redirect_valid=1, redirect_pc=32'h0000_0100 while in WAIT, ack 3 cycles later -> that word is dropped, next imem_addr=0x100, first valid pc_out=0x100.
REQ-042 flush alone with the buffer holding PCs 0x20 and 0x24 -> buffer empties, next imem_addr=0x20.
REQ-043 Assert reset while imem_req=1 -> imem_req=0 immediately; after release, imem_addr=RESET_PC.
REQ-044 redirect_pc=32'hFFFF_FFFC -> next fetch addresses are 0xFFFF_FFFC then 0x0000_0000.
